traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
Downstream consumer of the 2-bit traffic light phase code (00=Red, 01=Yellow, 10=Green).
- Checks the code stream for legal sequence and dwell-time limits.
- Drives registered one-hot lamp outputs.
- Latches a sticky fault and forces fail-safe lamps on any violation.
- Counts completed light cycles for the airport security status logic.

Parameters:
MIN_DWELL, 1, minimum consecutive samples a phase must last before it may change (≥1).
MAX_DWELL, 16, maximum consecutive samples a phase may last (>MIN_DWELL).
DWELL_W, 5, width of the dwell counter; must hold MAX_DWELL.
CNT_W, 8, width of cycle_count.
FLASH_HALF, 4, half-period in clocks of the fault flash (used only with TL_MON_FLASH_EN).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
light_in  input  2  phase code from the upstream light sequencer, sampled every clk
clear_fault  input  1  single-cycle request to leave FAULT
lamp_red  output  1  registered red lamp drive
lamp_yellow  output  1  registered yellow lamp drive
lamp_green  output  1  registered green lamp drive
fault  output  1  sticky fault flag
fault_code  output  3  0=none, 1=illegal code 11, 2=illegal transition, 3=dwell too short, 4=dwell too long
cycle_count  output  CNT_W  number of legal Green->Red transitions, modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n). All state is async-cleared.
- Reset values: state=INIT, lamp_red=1, lamp_yellow=0, lamp_green=0, fault=0, fault_code=0, cycle_count=0, dwell=0, prev_light=Red.
- States:
  - INIT: lamps solid red; no checking. When light_in==Red: go to RUN, prev_light=Red, dwell=1. Other codes are ignored.
  - RUN: each cycle, compare light_in with prev_light.
    - Same code: dwell increments, saturating at MAX_DWELL. A same-code sample when dwell==MAX_DWELL is a "too long" violation.
    - Legal change (Red->Yellow, Yellow->Green, Green->Red) with dwell≥MIN_DWELL: prev_light=light_in, dwell=1.
    - Green->Red additionally increments cycle_count, with wrap.
    - Change with dwell<MIN_DWELL is a "too short" violation.
    - Any other change (skip, reverse) is an "illegal transition" violation.
    - light_in==11 is an "illegal code" violation regardless of prev_light.
  - FAULT: lamps fail-safe, fault=1, fault_code held. If clear_fault=1: go to INIT next cycle with fault=0, fault_code=0, dwell=0.
- Violation priority within one sample: code 1 > 2 > 3 > 4. Only the highest is recorded.
- Latency:
  - Lamps follow light_in one cycle later in RUN; one-hot from the sampled code.
  - fault/fault_code assert the cycle after the offending sample, and lamps switch to fail-safe in that same cycle.
  - The offending sample never reaches the lamps.
- clear_fault outside FAULT has no effect.
- clear_fault in FAULT while light_in is illegal: still goes to INIT, since INIT does not check.
- A later fault never overwrites fault_code while in FAULT.
- cycle_count is not cleared by clear_fault, only by reset_n.
- reset_n low mid-operation: all outputs return to reset values immediately (asynchronously). Operation resumes in INIT after release.

Optional Feature:
TL_MON_FLASH_EN
- Defined: in FAULT, lamp_red=0, lamp_green=0, and lamp_yellow toggles every FLASH_HALF clocks. It starts at 1 on FAULT entry, and the flash counter resets on entry.
- Undefined: FAULT drives solid red (lamp_red=1, others 0), and no flash counter is built.

Decomposition:
- Shared package traffic_pkg:
  - light code constants LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN/LIGHT_ILLEGAL;
  - monitor state enum (INIT, RUN, FAULT);
  - fault code constants FLT_NONE..FLT_LONG.
- One natural sub-module: tl_dwell_counter, a saturating DWELL_W counter with load-to-1, clear and increment. The rest stays in the top module.

Test Plan:
1. MIN=1, MAX=16: reset, then Red,Red,Yellow,Green ×3, then Red -> fault stays 0, cycle_count=3, lamps track light_in one cycle delayed.
2. RUN, Red then Green -> next cycle fault=1, fault_code=2, lamp_red=1 (no macro); Green never shown.
3. RUN, light_in=11 for one cycle -> fault_code=1; a subsequent Yellow->Red skip leaves fault_code=1.
4. Green held 17 consecutive samples (MAX=16) -> fault_code=4 the cycle after the 17th sample. Green held exactly 16 samples then Red -> no fault.
5. MIN_DWELL=2: Red,Red,Yellow,Green -> fault_code=3 after the Green sample.
6. In FAULT:
   - pulse clear_fault while light_in=Yellow -> next cycle INIT, fault=0, lamps red, cycle_count unchanged; waits for Red before checking resumes.
   - Separately, drop reset_n mid-RUN -> outputs at reset values with no clk edge.
   - With TL_MON_FLASH_EN, FAULT lamp_yellow toggles every 4 clocks.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor: phase codes, monitor states,
// fault codes and lamp helpers.
package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t LIGHT_RED     = 2'b00;
  localparam light_t LIGHT_YELLOW  = 2'b01;
  localparam light_t LIGHT_GREEN   = 2'b10;
  localparam light_t LIGHT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_e;

  typedef logic [2:0] fault_code_t;

  localparam fault_code_t FLT_NONE  = 3'd0;
  localparam fault_code_t FLT_CODE  = 3'd1;
  localparam fault_code_t FLT_TRANS = 3'd2;
  localparam fault_code_t FLT_SHORT = 3'd3;
  localparam fault_code_t FLT_LONG  = 3'd4;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamps_t;

  localparam lamps_t LAMPS_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam lamps_t LAMPS_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam lamps_t LAMPS_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

  // Only the forward ring Red -> Yellow -> Green -> Red is a legal phase change.
  function automatic logic legal_next(light_t cur, light_t nxt);
    return (cur == LIGHT_RED    && nxt == LIGHT_YELLOW) ||
           (cur == LIGHT_YELLOW && nxt == LIGHT_GREEN)  ||
           (cur == LIGHT_GREEN  && nxt == LIGHT_RED);
  endfunction

  function automatic lamps_t light_to_lamps(light_t code);
    case (code)
      LIGHT_YELLOW: return LAMPS_YELLOW;
      LIGHT_GREEN:  return LAMPS_GREEN;
      default:      return LAMPS_RED;
    endcase
  endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Saturating dwell counter: clear to 0, load to 1 on a phase change, or count up
// to MAX_DWELL while the phase is held.
module tl_dwell_counter #(
  parameter int DWELL_W   = 5,
  parameter int MAX_DWELL = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               load_one,
  input  logic               inc,
  output logic [DWELL_W-1:0] dwell
);

  logic [DWELL_W-1:0] dwell_q, dwell_d;

  always_comb begin
    // NOTE: default assignment first, so no path through this block leaves
    // dwell_d unassigned and infers a latch.
    dwell_d = dwell_q;
    if (clr) begin
      dwell_d = '0;
    end else if (load_one) begin
      dwell_d = DWELL_W'(1);
    end else if (inc && (dwell_q != DWELL_W'(MAX_DWELL))) begin
      dwell_d = dwell_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments for every flop, so all registers update
    // together from values sampled before the edge.
    if (!reset_n) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

  assign dwell = dwell_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Checks the traffic light phase stream, drives registered lamps and latches a
// sticky fault. Define TL_MON_FLASH_EN for a flashing-yellow fail-safe display.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_DWELL  = 1,
  parameter int MAX_DWELL  = 16,
  parameter int DWELL_W    = 5,
  parameter int CNT_W      = 8,
  parameter int FLASH_HALF = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       light_in,
  input  logic             clear_fault,
  output logic             lamp_red,
  output logic             lamp_yellow,
  output logic             lamp_green,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] cycle_count
);

  mon_state_e       state_q, state_d;
  light_t           prev_q, prev_d;
  lamps_t           lamps_q, lamps_d;
  logic             fault_q, fault_d;
  fault_code_t      code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               dwell_clr, dwell_load, dwell_inc;
  logic [DWELL_W-1:0] dwell;
  fault_code_t        viol;

`ifdef TL_MON_FLASH_EN
  localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam lamps_t LAMPS_FAULT_ENTRY = LAMPS_YELLOW;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
`else
  localparam lamps_t LAMPS_FAULT_ENTRY = LAMPS_RED;
`endif

  tl_dwell_counter #(
    .DWELL_W   (DWELL_W),
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (dwell_clr),
    .load_one (dwell_load),
    .inc      (dwell_inc),
    .dwell    (dwell)
  );

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    lamps_d    = lamps_q;
    fault_d    = fault_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    dwell_clr  = 1'b0;
    dwell_load = 1'b0;
    dwell_inc  = 1'b0;
    viol       = FLT_NONE;
`ifdef TL_MON_FLASH_EN
    flash_cnt_d = flash_cnt_q;
`endif

    case (state_q)
      ST_INIT: begin
        lamps_d = LAMPS_RED;
        if (light_in == LIGHT_RED) begin
          state_d    = ST_RUN;
          prev_d     = LIGHT_RED;
          dwell_load = 1'b1;
        end
      end

      ST_RUN: begin
        // Checks are ordered so only the highest-priority violation is recorded.
        if (light_in == LIGHT_ILLEGAL) begin
          viol = FLT_CODE;
        end else if (light_in == prev_q) begin
          if (dwell == DWELL_W'(MAX_DWELL)) viol = FLT_LONG;
          else                              dwell_inc = 1'b1;
        end else if (!legal_next(prev_q, light_in)) begin
          viol = FLT_TRANS;
        end else if (dwell < DWELL_W'(MIN_DWELL)) begin
          viol = FLT_SHORT;
        end else begin
          prev_d     = light_in;
          dwell_load = 1'b1;
          if (prev_q == LIGHT_GREEN) cnt_d = cnt_q + CNT_W'(1);
        end

        if (viol != FLT_NONE) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = viol;
          lamps_d = LAMPS_FAULT_ENTRY;
`ifdef TL_MON_FLASH_EN
          flash_cnt_d = '0;
`endif
        end else begin
          lamps_d = light_to_lamps(light_in);
        end
      end

      ST_FAULT: begin
        if (clear_fault) begin
          state_d   = ST_INIT;
          fault_d   = 1'b0;
          code_d    = FLT_NONE;
          dwell_clr = 1'b1;
          lamps_d   = LAMPS_RED;
        end else begin
`ifdef TL_MON_FLASH_EN
          lamps_d.red   = 1'b0;
          lamps_d.green = 1'b0;
          if (flash_cnt_q == FLASH_W'(FLASH_HALF - 1)) begin
            flash_cnt_d    = '0;
            lamps_d.yellow = ~lamps_q.yellow;
          end else begin
            flash_cnt_d = flash_cnt_q + FLASH_W'(1);
          end
`else
          lamps_d = LAMPS_RED;
`endif
        end
      end

      default: begin
        state_d = ST_INIT;
        lamps_d = LAMPS_RED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      prev_q  <= LIGHT_RED;
      lamps_q <= LAMPS_RED;
      fault_q <= 1'b0;
      code_q  <= FLT_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      lamps_q <= lamps_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TL_MON_FLASH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
    end
  end
`endif

  assign lamp_red    = lamps_q.red;
  assign lamp_yellow = lamps_q.yellow;
  assign lamp_green  = lamps_q.green;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed, table-driven bench for traffic_light_monitor plus hand-written
// sequences for fault flash, asynchronous reset and a MIN_DWELL=2 instance.
module tb_traffic_light_monitor;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;
`ifdef TL_MON_FLASH_EN
  localparam logic [2:0] L_FS = 3'b010;
`else
  localparam logic [2:0] L_FS = 3'b100;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] light_in;
  logic       clear_fault;
  logic       lamp_red, lamp_yellow, lamp_green, fault;
  logic [2:0] fault_code;
  logic [7:0] cycle_count;

  logic [1:0] light2;
  logic       clr2;
  logic       lamp_red2, lamp_yellow2, lamp_green2, fault2;
  logic [2:0] fault_code2;
  logic [7:0] cycle_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .light_in    (light_in),
    .clear_fault (clear_fault),
    .lamp_red    (lamp_red),
    .lamp_yellow (lamp_yellow),
    .lamp_green  (lamp_green),
    .fault       (fault),
    .fault_code  (fault_code),
    .cycle_count (cycle_count)
  );

  traffic_light_monitor #(.MIN_DWELL(2)) dut_min2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .light_in    (light2),
    .clear_fault (clr2),
    .lamp_red    (lamp_red2),
    .lamp_yellow (lamp_yellow2),
    .lamp_green  (lamp_green2),
    .fault       (fault2),
    .fault_code  (fault_code2),
    .cycle_count (cycle_count2)
  );

  typedef struct {
    logic [1:0] light;
    logic       clr;
    logic [2:0] lamps;
    logic       flt;
    logic [2:0] code;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] light, input logic clr, input logic [2:0] lamps,
                     input logic flt, input logic [2:0] code, input logic [7:0] cnt);
    vec_t v;
    v.light = light;
    v.clr   = clr;
    v.lamps = lamps;
    v.flt   = flt;
    v.code  = code;
    v.cnt   = cnt;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [2:0] lamps, input logic flt,
                            input logic [2:0] code, input logic [7:0] cnt);
    check({tag, " lamps"}, {29'd0, lamp_red, lamp_yellow, lamp_green}, {29'd0, lamps});
    check({tag, " fault"}, {31'd0, fault}, {31'd0, flt});
    check({tag, " code"}, {29'd0, fault_code}, {29'd0, code});
    check({tag, " count"}, {24'd0, cycle_count}, {24'd0, cnt});
  endtask

  task automatic check_min2(input string tag, input logic [2:0] lamps, input logic flt,
                            input logic [2:0] code);
    check({tag, " lamps"}, {29'd0, lamp_red2, lamp_yellow2, lamp_green2}, {29'd0, lamps});
    check({tag, " fault"}, {31'd0, fault2}, {31'd0, flt});
    check({tag, " code"}, {29'd0, fault_code2}, {29'd0, code});
  endtask

  initial begin
    logic [2:0] exp_lamps;

    // Legal cycles, then illegal transition, clear, illegal code, dwell limits.
    add(R, 1'b0, L_R, 1'b0, 3'd0, 8'd0);
    add(R, 1'b0, L_R, 1'b0, 3'd0, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      add(Y, 1'b0, L_Y, 1'b0, 3'd0, 8'(k - 1));
      add(G, 1'b0, L_G, 1'b0, 3'd0, 8'(k - 1));
      add(R, 1'b0, L_R, 1'b0, 3'd0, 8'(k));
    end
    add(Y, 1'b1, L_Y, 1'b0, 3'd0, 8'd3);
    add(G, 1'b0, L_G, 1'b0, 3'd0, 8'd3);
    add(R, 1'b0, L_R, 1'b0, 3'd0, 8'd4);
    add(G, 1'b0, L_FS, 1'b1, 3'd2, 8'd4);
    add(Y, 1'b1, L_R, 1'b0, 3'd0, 8'd4);
    add(Y, 1'b0, L_R, 1'b0, 3'd0, 8'd4);
    add(G, 1'b0, L_R, 1'b0, 3'd0, 8'd4);
    add(R, 1'b0, L_R, 1'b0, 3'd0, 8'd4);
    add(X, 1'b0, L_FS, 1'b1, 3'd1, 8'd4);
    add(Y, 1'b0, L_FS, 1'b1, 3'd1, 8'd4);
    add(R, 1'b0, L_FS, 1'b1, 3'd1, 8'd4);
    add(X, 1'b1, L_R, 1'b0, 3'd0, 8'd4);
    add(X, 1'b0, L_R, 1'b0, 3'd0, 8'd4);
    add(R, 1'b0, L_R, 1'b0, 3'd0, 8'd4);
    add(Y, 1'b0, L_Y, 1'b0, 3'd0, 8'd4);
    for (int k = 0; k < 16; k++) add(G, 1'b0, L_G, 1'b0, 3'd0, 8'd4);
    add(R, 1'b0, L_R, 1'b0, 3'd0, 8'd5);
    add(Y, 1'b0, L_Y, 1'b0, 3'd0, 8'd5);
    for (int k = 0; k < 16; k++) add(G, 1'b0, L_G, 1'b0, 3'd0, 8'd5);
    add(G, 1'b0, L_FS, 1'b1, 3'd4, 8'd5);

    reset_n     = 1'b0;
    light_in    = R;
    clear_fault = 1'b0;
    light2      = Y;
    clr2        = 1'b0;
    step();
    step();
    check_main("reset", L_R, 1'b0, 3'd0, 8'd0);
    check_min2("reset min2", L_R, 1'b0, 3'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      light_in    = vecs[i].light;
      clear_fault = vecs[i].clr;
      step();
      check_main($sformatf("vec%0d", i), vecs[i].lamps, vecs[i].flt, vecs[i].code, vecs[i].cnt);
    end

    // Remain in FAULT (too long) and watch the fail-safe display.
    light_in    = G;
    clear_fault = 1'b0;
    for (int k = 1; k < 10; k++) begin
`ifdef TL_MON_FLASH_EN
      exp_lamps = (((k / 4) % 2) == 0) ? L_Y : 3'b000;
`else
      exp_lamps = L_R;
`endif
      step();
      check_main($sformatf("hold%0d", k), exp_lamps, 1'b1, 3'd4, 8'd5);
    end

    // Clear, re-enter RUN, then drop reset between clock edges.
    light_in    = R;
    clear_fault = 1'b1;
    step();
    check_main("clear2", L_R, 1'b0, 3'd0, 8'd5);
    clear_fault = 1'b0;
    step();
    light_in = Y;
    step();
    check_main("pre reset", L_Y, 1'b0, 3'd0, 8'd5);
    #3;
    reset_n = 1'b0;
    #1;
    check_main("async reset", L_R, 1'b0, 3'd0, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_main("post reset Y", L_R, 1'b0, 3'd0, 8'd0);
    light_in = G;
    step();
    check_main("post reset G", L_R, 1'b0, 3'd0, 8'd0);

    // MIN_DWELL=2 instance: Yellow held one sample is too short.
    light2 = R;
    step();
    check_min2("min2 r1", L_R, 1'b0, 3'd0);
    step();
    check_min2("min2 r2", L_R, 1'b0, 3'd0);
    light2 = Y;
    step();
    check_min2("min2 y", L_Y, 1'b0, 3'd0);
    light2 = G;
    step();
    check_min2("min2 g", L_FS, 1'b1, 3'd3);
    check("min2 count", {24'd0, cycle_count2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
